// File: rtl/ibuf_mem_writer.sv
// ibuf_mem_writer: takes a (base, count) command and a beat stream, and
// issues one registered write per accepted beat into the input buffer.
// Write addresses use {row_addr, buf_id} packing, so consecutive beats
// alternate bank groups before the row advances.
module ibuf_mem_writer #(
  parameter  int unsigned MEM_DATA_WIDTH = 64,
  parameter  int unsigned ARRAY_N        = 8,
  parameter  int unsigned DATA_WIDTH     = 16,
  parameter  int unsigned BUF_ADDR_WIDTH = 10,
  localparam int unsigned GROUP_SIZE     = MEM_DATA_WIDTH / DATA_WIDTH,
  localparam int unsigned GROUP_ID_W     = (GROUP_SIZE == 1) ? 0 : $clog2(GROUP_SIZE),
  localparam int unsigned BUF_ID_W       = $clog2(ARRAY_N) - GROUP_ID_W,
  localparam int unsigned MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + BUF_ID_W,
  localparam int unsigned NUM_W          = MEM_ADDR_WIDTH + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [MEM_ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [NUM_W-1:0]          cmd_num_words,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [MEM_DATA_WIDTH-1:0] s_data,
  input  logic                      s_last,
  output logic                      mem_write_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_write_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_write_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                    state_q, state_d;

  logic [MEM_ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
  logic [NUM_W-1:0]          rem_cnt_q,  rem_cnt_d;

  logic                      wr_req_q,   wr_req_d;
  logic [MEM_ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;
  logic [MEM_DATA_WIDTH-1:0] wr_data_q,  wr_data_d;
  logic                      done_q,     done_d;
  logic                      err_q,      err_d;
  logic                      busy_q,     busy_d;
  logic                      cmd_rdy_q,  cmd_rdy_d;
  logic                      s_rdy_q,    s_rdy_d;

  logic                      cmd_acc_c;
  logic                      beat_acc_c;
  logic                      last_beat_c;

  // Handshake qualifiers: commands only in IDLE, beats only in XFER.
  assign cmd_acc_c   = (state_q == ST_IDLE) && cmd_valid;
  assign beat_acc_c  = (state_q == ST_XFER) && s_valid;
  assign last_beat_c = (rem_cnt_q == NUM_W'(1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a zero-length command skips straight to DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = (cmd_num_words != NUM_W'(0)) ? ST_XFER : ST_DONE;
        end
      end
      ST_XFER: begin
        if (beat_acc_c && last_beat_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output and counter next values; status outputs track the next state
  // so they line up with the registered state.
  always_comb begin
    addr_cnt_d = addr_cnt_q;
    rem_cnt_d  = rem_cnt_q;
    wr_req_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_d      = err_q;
    done_d     = (state_d == ST_DONE);
    busy_d     = (state_d != ST_IDLE);
    cmd_rdy_d  = (state_d == ST_IDLE);
    s_rdy_d    = (state_d == ST_XFER);

    if (cmd_acc_c) begin
      addr_cnt_d = cmd_base_addr;
      rem_cnt_d  = cmd_num_words;
      err_d      = 1'b0;
    end

    if (beat_acc_c) begin
      wr_req_d   = 1'b1;
      wr_addr_d  = addr_cnt_q;
      wr_data_d  = s_data;
      addr_cnt_d = addr_cnt_q + MEM_ADDR_WIDTH'(1);
      rem_cnt_d  = rem_cnt_q - NUM_W'(1);
      // Marker mismatch is flagged but never changes the transfer length.
      if (s_last != last_beat_c) begin
        err_d = 1'b1;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_cnt_q <= '0;
      rem_cnt_q  <= '0;
      wr_req_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      cmd_rdy_q  <= 1'b1;
      s_rdy_q    <= 1'b0;
    end else begin
      addr_cnt_q <= addr_cnt_d;
      rem_cnt_q  <= rem_cnt_d;
      wr_req_q   <= wr_req_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      cmd_rdy_q  <= cmd_rdy_d;
      s_rdy_q    <= s_rdy_d;
    end
  end

  assign mem_write_req  = wr_req_q;
  assign mem_write_addr = wr_addr_q;
  assign mem_write_data = wr_data_q;
  assign done           = done_q;
  assign err            = err_q;
  assign busy           = busy_q;
  assign cmd_ready      = cmd_rdy_q;
  assign s_ready        = s_rdy_q;

endmodule

// File: tb/tb_ibuf_mem_writer.sv
// Scoreboard bench for ibuf_mem_writer: the driver pushes expected writes
// and completion events as beats are handed over; a negedge monitor pops
// and compares whenever the DUT shows a write or done.
module tb_ibuf_mem_writer;

  localparam int unsigned AW = 11;
  localparam int unsigned NW = 12;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base_addr = '0;
  logic [NW-1:0] cmd_num_words = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          mem_write_req;
  logic [AW-1:0] mem_write_addr;
  logic [DW-1:0] mem_write_data;
  logic          busy;
  logic          done;
  logic          err;

  ibuf_mem_writer dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_base_addr (cmd_base_addr),
    .cmd_num_words (cmd_num_words),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_last        (s_last),
    .mem_write_req (mem_write_req),
    .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            done;
    bit            err;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write or done must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (reset && (mem_write_req || done)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: req=%0b done=%0b addr=%0h, expected no output",
                 mem_write_req, done, mem_write_addr);
      end else begin
        e = exp_q.pop_front();
        check("wr_req", 64'(mem_write_req), 64'(e.is_wr));
        if (e.is_wr) begin
          check("wr_addr", 64'(mem_write_addr), 64'(e.addr));
          check("wr_data", mem_write_data, e.data);
        end
        check("done_with_evt", 64'(done), 64'(e.done));
        if (e.done) check("err_at_done", 64'(err), 64'(e.err));
        check("latency_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // mode: 0 back-to-back, 1 alternating valid, 2 random gaps.
  // bad_idx: beat index whose s_last marker is flipped (-1 for none).
  task automatic run_cmd(input int base, input int num, input int mode,
                         input int bad_idx, input bit inject);
    int  i, k, to;
    bit  v, exp_err;
    exp_t e;
    logic [AW-1:0] a;
    exp_err = (bad_idx >= 0) && (bad_idx < num);
    to = 0;
    while (!cmd_ready && to < 20) begin
      @(posedge clk); #1; to++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL cmd_ready_timeout: got 0 expected 1");
    end
    cmd_valid     = 1'b1;
    cmd_base_addr = AW'(base);
    cmd_num_words = NW'(num);
    if (num == 0) begin
      e = '{is_wr: 0, addr: '0, data: '0, done: 1, err: 0, cyc: cyc + 1};
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("err_clear_on_cmd", 64'(err), 64'd0);
    i = 0; k = 0; to = 0;
    while (i < num && to < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (k % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      s_valid = v;
      s_data  = {$urandom, $urandom};
      s_last  = (i == num - 1) ^ (i == bad_idx);
      cmd_valid = inject && ($urandom_range(0, 2) == 0);
      cmd_base_addr = AW'($urandom);
      if (v && s_ready) begin
        a = AW'(base + i);
        e = '{is_wr: 1, addr: a, data: s_data, done: (i == num - 1),
              err: exp_err, cyc: cyc + 1};
        exp_q.push_back(e);
        i++;
      end
      k++; to++;
      @(posedge clk); #1;
    end
    if (i < num) begin
      n_cmp++; n_fail++;
      $display("FAIL beat_timeout: accepted %0d expected %0d", i, num);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    cmd_valid = 1'b0;
    check("done_pulse", 64'(done), 64'd1);
    check("busy_in_done", 64'(busy), 64'd1);
    check("cmd_ready_in_done", 64'(cmd_ready), 64'd0);
    if (num == 0) check("s_ready_zero_cmd", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    check("done_single", 64'(done), 64'd0);
    check("busy_fall", 64'(busy), 64'd0);
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    check("err_sticky", 64'(err), 64'(exp_err));
  endtask

  initial begin
    int n;
    exp_t e;
    // Reset state
    #12;
    check("rst_req", 64'(mem_write_req), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_cmd(0, 4, 0, -1, 0);          // basic back-to-back
    run_cmd(11'h7FE, 4, 0, -1, 0);    // address wrap
    run_cmd(0, 0, 0, -1, 0);          // zero count
    run_cmd(11'h040, 3, 1, 1, 0);     // gaps, early s_last
    run_cmd(11'h050, 2, 0, -1, 0);    // err cleared by next command
    run_cmd(11'h100, 6, 2, -1, 1);    // ignored commands during XFER
    run_cmd(11'h200, 3, 0, 2, 0);     // missing s_last on final beat

    // Reset mid-transfer after 2 of 5 beats
    cmd_valid = 1'b1; cmd_base_addr = AW'(11'h020); cmd_num_words = NW'(5);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      s_valid = 1'b1; s_data = {$urandom, $urandom}; s_last = 1'b0;
      e = '{is_wr: 1, addr: AW'(11'h020 + b), data: s_data, done: 0, err: 0, cyc: cyc + 1};
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check("mid_rst_req", 64'(mem_write_req), 64'd0);
    check("mid_rst_addr", 64'(mem_write_addr), 64'd0);
    check("mid_rst_data", mem_write_data, 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_s_ready", 64'(s_ready), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    s_valid = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      s_data = {$urandom, $urandom};
      @(posedge clk); #1;
      check("post_rst_s_ready", 64'(s_ready), 64'd0);
    end
    s_valid = 1'b0;
    run_cmd(11'h010, 1, 0, -1, 0);

    // Randomized commands
    for (int r = 0; r < 25; r++) begin
      n = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
      run_cmd(int'($urandom_range(0, 2047)), n, int'($urandom_range(0, 2)),
              ($urandom_range(0, 3) == 0 && n > 0) ? int'($urandom_range(0, n - 1)) : -1,
              $urandom_range(0, 1) == 1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
